// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external simple dual-port synchronous RAM.
// Owns pointers, occupancy and status flags; read data is the RAM's registered output.
module ram_fifo_ctrl #(
    parameter int RAM_WIDTH = 8,
    parameter int ADDR_SIZE = 8,
    parameter int AF_LEVEL  = 240
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 push,
    input  logic [RAM_WIDTH-1:0] wr_data,
    input  logic                 pop,
    output logic [RAM_WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 ram_rst,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_wr_addr,
    output logic [RAM_WIDTH-1:0] ram_data_in,
    output logic                 ram_re,
    output logic [ADDR_SIZE-1:0] ram_rd_addr,
    input  logic [RAM_WIDTH-1:0] ram_data_out
);

    localparam int CW = ADDR_SIZE + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(1) << ADDR_SIZE;
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

    logic [CW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          full_reg, empty_reg, almost_full_reg;
    logic          rd_valid_reg, overflow_reg, underflow_reg;
    logic          accept_en, push_ok, pop_ok;

    // Nothing is accepted on a reset or flush edge, so the RAM sees no stray access.
    always_comb begin
        accept_en   = rst_n & ~clr;
        push_ok     = push & ~full_reg & accept_en;
        pop_ok      = pop & ~empty_reg & accept_en;
        wr_ptr_next = wr_ptr_reg + CW'(push_ok);
        rd_ptr_next = rd_ptr_reg + CW'(pop_ok);
        count_next  = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            full_reg        <= 1'b0;
            empty_reg       <= 1'b1;
            almost_full_reg <= 1'b0;
            rd_valid_reg    <= 1'b0;
            overflow_reg    <= 1'b0;
            underflow_reg   <= 1'b0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
            // Flags track the count being registered on this same edge.
            full_reg        <= (count_next == DEPTH_C);
            empty_reg       <= (count_next == '0);
            almost_full_reg <= (count_next >= AF_C);
            rd_valid_reg    <= pop_ok;
            overflow_reg    <= overflow_reg | (push & full_reg);
            underflow_reg   <= underflow_reg | (pop & empty_reg);
        end
    end

    assign rd_data     = ram_data_out;
    assign rd_valid    = rd_valid_reg;
    assign full        = full_reg;
    assign empty       = empty_reg;
    assign almost_full = almost_full_reg;
    assign count       = count_reg;
    assign overflow    = overflow_reg;
    assign underflow   = underflow_reg;

    assign ram_rst     = ~rst_n;
    assign ram_we      = push_ok;
    assign ram_wr_addr = wr_ptr_reg[ADDR_SIZE-1:0];
    assign ram_data_in = wr_data;
    assign ram_re      = pop_ok;
    assign ram_rd_addr = rd_ptr_reg[ADDR_SIZE-1:0];

endmodule
